alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu.sv | 44 ++++
 rtl/alu_arbiter.sv | 110 +++++++++++
 tb/tb_alu_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Definitions shared by the ALU and the arbiter around it: funct3 operation
// encoding and the default datapath width.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    ADD_SUB = 3'b000,
    SLL     = 3'b001,
    SLT     = 3'b010,
    SLTU    = 3'b011,
    XOR     = 3'b100,
    SR      = 3'b101,
    OR      = 3'b110,
    AND     = 3'b111
  } alu_op_t;

endpackage

// File: rtl/alu.sv
// Combinational RV32-style integer ALU. i_alt selects subtract for ADD_SUB
// and arithmetic shift for SR; shift amounts come from i_b[4:0].
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  alu_op_t         i_op,
  input  logic            i_alt,
  output logic [XLEN-1:0] o_y
);

  logic [4:0] w_shamt;
  logic       w_lt_s;
  logic       w_lt_u;

  assign w_shamt = i_b[4:0];
  assign w_lt_s  = $signed(i_a) < $signed(i_b);
  assign w_lt_u  = i_a < i_b;

  always_comb begin
    o_y = '0;
    case (i_op)
      ADD_SUB: begin
        if (i_alt) o_y = i_a - i_b;
        else       o_y = i_a + i_b;
      end
      SLL:  o_y = i_a << w_shamt;
      SLT:  o_y = {{(XLEN-1){1'b0}}, w_lt_s};
      SLTU: o_y = {{(XLEN-1){1'b0}}, w_lt_u};
      XOR:  o_y = i_a ^ i_b;
      SR: begin
        if (i_alt) o_y = $unsigned($signed(i_a) >>> w_shamt);
        else       o_y = i_a >> w_shamt;
      end
      OR:   o_y = i_a | i_b;
      AND:  o_y = i_a & i_b;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of a single shared ALU with a one-deep
// registered result stage (valid/ready on both sides).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREQ = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NREQ-1:0]                req_valid,
  output logic [NREQ-1:0]                req_ready,
  input  logic [NREQ-1:0][XLEN-1:0]      req_a,
  input  logic [NREQ-1:0][XLEN-1:0]      req_b,
  input  logic [NREQ-1:0][2:0]           req_op,
  input  logic [NREQ-1:0]                req_alt,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [$clog2(NREQ)-1:0]        rsp_id,
  output logic [XLEN-1:0]                rsp_result
);

  localparam int IDW = $clog2(NREQ);

  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [XLEN-1:0] r_rsp_result;
  logic [IDW-1:0]  r_last_grant;

  logic            w_accept;
  logic            w_any;
  logic            w_xfer;
  logic [IDW-1:0]  w_grant_idx;
  logic [NREQ-1:0] w_grant;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [2:0]      w_op_bits;
  logic            w_alt;
  alu_op_t         w_op;
  logic [XLEN-1:0] w_y;
  int unsigned     v_cand;

  // Search starts one past the last winner and wraps, so the last winner
  // is considered last.
  always_comb begin
    w_any       = 1'b0;
    w_grant_idx = '0;
    v_cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      v_cand = 32'(r_last_grant) + 32'(k);
      if (v_cand >= 32'(NREQ)) v_cand = v_cand - 32'(NREQ);
      if (!w_any && req_valid[v_cand[IDW-1:0]]) begin
        w_any       = 1'b1;
        w_grant_idx = v_cand[IDW-1:0];
      end
    end
  end

  assign w_grant   = w_any ? ({{(NREQ-1){1'b0}}, 1'b1} << w_grant_idx) : '0;
  assign w_accept  = !r_rsp_valid || rsp_ready;
  assign w_xfer    = rst_n && w_accept && w_any;
  assign req_ready = w_xfer ? w_grant : '0;

  // One-hot AND-OR operand mux feeding the single ALU instance.
  always_comb begin
    w_a       = '0;
    w_b       = '0;
    w_op_bits = '0;
    w_alt     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_a       = w_a | req_a[i];
        w_b       = w_b | req_b[i];
        w_op_bits = w_op_bits | req_op[i];
        w_alt     = w_alt | req_alt[i];
      end
    end
  end

  assign w_op = alu_op_t'(w_op_bits);

  alu #(.XLEN(XLEN)) u_alu (
    .i_a   (w_a),
    .i_b   (w_b),
    .i_op  (w_op),
    .i_alt (w_alt),
    .o_y   (w_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_last_grant <= IDW'(NREQ - 1);
    end else if (w_xfer) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_id     <= w_grant_idx;
      r_rsp_result <= w_y;
      r_last_grant <= w_grant_idx;
    end else if (rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scenario bench for alu_arbiter: granted operations are scored against a
// reference ALU model and popped when the registered response appears.
module tb_alu_arbiter;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0][2:0]  req_op;
  logic [1:0]       req_alt;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [0:0]       rsp_id;
  logic [31:0]      rsp_result;

  typedef struct {
    int          id;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_arbiter #(.XLEN(32), .NREQ(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .req_alt    (req_alt),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input logic alt);
    logic [63:0] ext;
    logic [31:0] r;
    r = 32'h0;
    case (op)
      3'd0: r = alt ? (a + ~b + 32'd1) : (a + b);
      3'd1: r = a << b[4:0];
      3'd2: r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
      3'd3: r = {31'd0, (a < b)};
      3'd4: r = a ^ b;
      3'd5: begin
        ext = {(alt ? {32{a[31]}} : 32'h0), a};
        ext = ext >> b[4:0];
        r   = ext[31:0];
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_xfers();
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        x.id  = i;
        x.res = ref_alu(req_a[i], req_b[i], req_op[i], req_alt[i]);
        sb.push_back(x);
      end
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic alt);
    req_a[i]   = a;
    req_b[i]   = b;
    req_op[i]  = op;
    req_alt[i] = alt;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    set_req(0, 32'd1, 32'd1, 3'd0, 1'b0);
    set_req(1, 32'd2, 32'd2, 3'd0, 1'b0);
    #2;
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got valid=%0b id=%0d result=%h exp 0/0/0",
               rsp_valid, rsp_id, rsp_result);
    end
    tick();
    n_checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready got req_ready=%b valid=%0b exp 00/0", req_ready, rsp_valid);
    end
    req_valid = 2'b00;
    rst_n     = 1'b1;
  endtask

  task automatic test_single();
    req_valid = 2'b01;
    set_req(0, 32'd5, 32'd3, 3'd0, 1'b1);
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL single_ready got=%b exp=01", req_ready);
    end
    push_xfers();
    tick();
    req_valid = 2'b00;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd2) begin
      n_fail++;
      $display("FAIL single_rsp got valid=%0b id=%0d result=%h exp 1/0/00000002",
               rsp_valid, rsp_id, rsp_result);
    end
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL single_sb got empty scoreboard exp one entry");
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (rsp_id !== 1'(e.id) || rsp_result !== e.res) begin
        n_fail++;
        $display("FAIL single_sb got id=%0d result=%h exp id=%0d result=%h",
                 rsp_id, rsp_result, e.id, e.res);
      end
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'd2 || rsp_id !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain got valid=%0b id=%0d result=%h exp 0/0/00000002",
               rsp_valid, rsp_id, rsp_result);
    end
  endtask

  task automatic test_contention();
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    req_valid = 2'b11;
    set_req(0, 32'h8000_0000, 32'd4, 3'd5, 1'b1);
    set_req(1, 32'd1, 32'd2, 3'd3, 1'b0);
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL contention_first_ready got=%b exp=01", req_ready);
    end
    push_xfers();
    tick();
    req_valid = 2'b10;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'hF800_0000) begin
      n_fail++;
      $display("FAIL contention_first got valid=%0b id=%0d result=%h exp 1/0/f8000000",
               rsp_valid, rsp_id, rsp_result);
    end
    if (sb.size() > 0) void'(sb.pop_front());
    #1;
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL contention_second_ready got=%b exp=10", req_ready);
    end
    push_xfers();
    tick();
    req_valid = 2'b00;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'd1) begin
      n_fail++;
      $display("FAIL contention_second got valid=%0b id=%0d result=%h exp 1/1/00000001",
               rsp_valid, rsp_id, rsp_result);
    end
    if (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic test_round_robin();
    int w;
    req_valid = 2'b11;
    for (int i = 0; i < 2; i++)
      set_req(i, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    for (int k = 0; k < 6; k++) begin
      w = k % 2;
      #1;
      n_checks++;
      if (req_ready !== (w == 0 ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL rr_ready[%0d] got=%b exp_winner=%0d", k, req_ready, w);
      end
      push_xfers();
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'(w)) begin
        n_fail++;
        $display("FAIL rr_id[%0d] got valid=%0b id=%0d exp 1/%0d", k, rsp_valid, rsp_id, w);
      end
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rr_sb[%0d] got empty scoreboard exp one entry", k);
      end else begin
        e = sb.pop_front();
        n_checks++;
        if (rsp_id !== 1'(e.id) || rsp_result !== e.res) begin
          n_fail++;
          $display("FAIL rr_sb[%0d] got id=%0d result=%h exp id=%0d result=%h",
                   k, rsp_id, rsp_result, e.id, e.res);
        end
      end
      set_req(w, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    logic [31:0] hold_res;
    req_valid = 2'b01;
    set_req(0, 32'h1234_5678, 32'h0F0F_0F0F, 3'd4, 1'b0);
    #1;
    push_xfers();
    tick();
    hold_res = 32'h1D3B_5977;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== hold_res) begin
      n_fail++;
      $display("FAIL bp_first got valid=%0b id=%0d result=%h exp 1/0/%h",
               rsp_valid, rsp_id, rsp_result, hold_res);
    end
    if (sb.size() > 0) void'(sb.pop_front());
    rsp_ready = 1'b0;
    req_valid = 2'b10;
    set_req(1, 32'd10, 32'd3, 3'd1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (req_ready !== 2'b00 || rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== hold_res) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got ready=%b valid=%0b id=%0d result=%h exp 00/1/0/%h",
                 c, req_ready, rsp_valid, rsp_id, rsp_result, hold_res);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_release_ready got=%b exp=10", req_ready);
    end
    push_xfers();
    tick();
    req_valid = 2'b00;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'd80) begin
      n_fail++;
      $display("FAIL bp_release got valid=%0b id=%0d result=%h exp 1/1/00000050",
               rsp_valid, rsp_id, rsp_result);
    end
    if (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic test_signed();
    logic [31:0] t_a   [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1,
                               32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] t_b   [7] = '{32'd1, 32'd1, 32'd1, 32'd33, 32'd31, 32'd31, 32'h8000_0000};
    logic [2:0]  t_op  [7] = '{3'd2, 3'd3, 3'd0, 3'd1, 3'd5, 3'd5, 3'd2};
    logic        t_alt [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] t_exp [7] = '{32'd1, 32'd0, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFF, 32'd0};
    for (int k = 0; k < 7; k++) begin
      req_valid = 2'b01;
      set_req(0, t_a[k], t_b[k], t_op[k], t_alt[k]);
      #1;
      push_xfers();
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== t_exp[k]) begin
        n_fail++;
        $display("FAIL alu_case[%0d] got valid=%0b result=%h exp 1/%h",
                 k, rsp_valid, rsp_result, t_exp[k]);
      end
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL alu_sb[%0d] got empty scoreboard exp one entry", k);
      end else begin
        e = sb.pop_front();
        n_checks++;
        if (rsp_id !== 1'(e.id) || rsp_result !== e.res) begin
          n_fail++;
          $display("FAIL alu_sb[%0d] got id=%0d result=%h exp id=%0d result=%h",
                   k, rsp_id, rsp_result, e.id, e.res);
        end
      end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b10;
    set_req(1, 32'd100, 32'd23, 3'd0, 1'b0);
    #1;
    push_xfers();
    tick();
    if (sb.size() > 0) void'(sb.pop_front());
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'd123) begin
      n_fail++;
      $display("FAIL rmid_pending got valid=%0b id=%0d result=%h exp 1/1/0000007b",
               rsp_valid, rsp_id, rsp_result);
    end
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_result !== 32'h0 || req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL rmid_async got valid=%0b id=%0d result=%h ready=%b exp 0/0/0/00",
               rsp_valid, rsp_id, rsp_result, req_ready);
    end
    sb.delete();
    tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    set_req(0, 32'd6, 32'd3, 3'd7, 1'b0);
    set_req(1, 32'd9, 32'd4, 3'd6, 1'b0);
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL rmid_priority got=%b exp=01", req_ready);
    end
    req_valid = 2'b10;
    #1;
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL rmid_req1_ready got=%b exp=10", req_ready);
    end
    push_xfers();
    tick();
    req_valid = 2'b00;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'd13) begin
      n_fail++;
      $display("FAIL rmid_req1 got valid=%0b id=%0d result=%h exp 1/1/0000000d",
               rsp_valid, rsp_id, rsp_result);
    end
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL rmid_sb got empty scoreboard exp one entry");
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (rsp_id !== 1'(e.id) || rsp_result !== e.res) begin
        n_fail++;
        $display("FAIL rmid_sb got id=%0d result=%h exp id=%0d result=%h",
                 rsp_id, rsp_result, e.id, e.res);
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_round_robin();
    test_backpressure();
    test_signed();
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover got=%0d entries exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
